// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue path and the xlu unit.
// Class encodings, xlu opcodes, default occupancies and controller states.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_cls_t;

  typedef logic [2:0] xlu_op_t;

  localparam xlu_op_t XLU_MULT  = 3'b000;
  localparam xlu_op_t XLU_MULTU = 3'b001;
  localparam xlu_op_t XLU_DIV   = 3'b010;
  localparam xlu_op_t XLU_DIVU  = 3'b011;
  localparam xlu_op_t XLU_MTHI  = 3'b100;
  localparam xlu_op_t XLU_MTLO  = 3'b101;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } md_st_t;

  // Classes that never reach xlu (MF*, NONE, 9..15) map to the idle opcode.
  function automatic xlu_op_t cls_to_op(input logic [3:0] cls);
    xlu_op_t op;
    op = XLU_MULT;
    case (cls)
      MD_MULT:  op = XLU_MULT;
      MD_MULTU: op = XLU_MULTU;
      MD_DIV:   op = XLU_DIV;
      MD_DIVU:  op = XLU_DIVU;
      MD_MTHI:  op = XLU_MTHI;
      MD_MTLO:  op = XLU_MTLO;
      default:  op = XLU_MULT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Occupancy countdown for xlu: loads the op latency on issue and counts to zero.
// Asynchronous active-low clear so a mid-operation reset frees the unit at once.
module md_busy_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/md_issue.sv
// E-stage issue and hazard control for xlu: decodes the MD class, strobes xlu,
// tracks its fixed latency, stalls dependent MD instructions and muxes HI/LO.
module md_issue
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic        e_flush,
  input  logic [3:0]  e_md_cls,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  output logic        xlu_start,
  output logic [2:0]  xlu_op,
  output logic [31:0] xlu_in1,
  output logic [31:0] xlu_in2,
  input  logic [31:0] hi_out,
  input  logic [31:0] lo_out,
  output logic        stall,
  output logic        busy,
  output logic [31:0] mf_data
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  md_st_t st, st_nxt;

  logic          is_mul, is_div, is_mt, is_mfhi, is_mflo;
  logic          live, md_any;
  logic          cnt_load, cnt_last;
  logic [CW-1:0] cnt_load_val, cnt;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mt   = 1'b0;
    is_mfhi = 1'b0;
    is_mflo = 1'b0;
    case (e_md_cls)
      MD_MULT, MD_MULTU: is_mul  = 1'b1;
      MD_DIV, MD_DIVU:   is_div  = 1'b1;
      MD_MTHI, MD_MTLO:  is_mt   = 1'b1;
      MD_MFHI:           is_mfhi = 1'b1;
      MD_MFLO:           is_mflo = 1'b1;
      default: ;
    endcase
  end

  // Hazard check stays combinational on st so a flush drops stall the same cycle.
  assign live      = e_valid & ~e_flush;
  assign md_any    = live & (is_mul | is_div | is_mt | is_mfhi | is_mflo);
  assign stall     = md_any & (st != IDLE);
  assign xlu_start = live & ~stall & (is_mul | is_div | is_mt);
  assign xlu_op    = xlu_start ? cls_to_op(e_md_cls) : XLU_MULT;
  assign xlu_in1   = e_rs;
  assign xlu_in2   = e_rt;

  assign cnt_load     = xlu_start & (is_mul | is_div);
  assign cnt_load_val = is_div ? DIV_LD : MULT_LD;

  md_busy_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // A zero count in a busy state also returns to IDLE so a zero latency cannot hang.
  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: begin
        if (xlu_start && is_mul) begin
          st_nxt = MUL_BUSY;
        end else if (xlu_start && is_div) begin
          st_nxt = DIV_BUSY;
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        if (cnt_last || cnt == '0) begin
          st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign busy = (st != IDLE);

  always_comb begin
    mf_data = '0;
    if (is_mfhi) begin
      mf_data = hi_out;
    end else if (is_mflo) begin
      mf_data = lo_out;
    end
  end

endmodule

// File: tb/tb_md_issue.sv
// Directed bench for md_issue with a small behavioural xlu supplying HI/LO.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_md_issue;

  logic        clk;
  logic        reset;
  logic        e_valid;
  logic        e_flush;
  logic [3:0]  e_md_cls;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        xlu_start;
  logic [2:0]  xlu_op;
  logic [31:0] xlu_in1;
  logic [31:0] xlu_in2;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        stall;
  logic        busy;
  logic [31:0] mf_data;

  int tests_run;
  int tests_failed;

  localparam logic [3:0] C_NONE  = 4'd0;
  localparam logic [3:0] C_MULT  = 4'd1;
  localparam logic [3:0] C_DIV   = 4'd3;
  localparam logic [3:0] C_DIVU  = 4'd4;
  localparam logic [3:0] C_MTHI  = 4'd5;
  localparam logic [3:0] C_MTLO  = 4'd6;
  localparam logic [3:0] C_MFHI  = 4'd7;
  localparam logic [3:0] C_MFLO  = 4'd8;

  md_issue dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_flush   (e_flush),
    .e_md_cls  (e_md_cls),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .xlu_start (xlu_start),
    .xlu_op    (xlu_op),
    .xlu_in1   (xlu_in1),
    .xlu_in2   (xlu_in2),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .stall     (stall),
    .busy      (busy),
    .mf_data   (mf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural xlu: results land at the issue edge, well inside the latency contract.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (xlu_start) begin
      case (xlu_op)
        3'b000: {hi_out, lo_out} <= 64'($signed(xlu_in1)) * 64'($signed(xlu_in2));
        3'b001: {hi_out, lo_out} <= {32'd0, xlu_in1} * {32'd0, xlu_in2};
        3'b010: if (xlu_in2 != 0) begin
                  lo_out <= 32'($signed(xlu_in1) / $signed(xlu_in2));
                  hi_out <= 32'($signed(xlu_in1) % $signed(xlu_in2));
                end
        3'b011: if (xlu_in2 != 0) begin
                  lo_out <= xlu_in1 / xlu_in2;
                  hi_out <= xlu_in1 % xlu_in2;
                end
        3'b100: hi_out <= xlu_in1;
        3'b101: lo_out <= xlu_in1;
        default: ;
      endcase
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic [3:0] cls,
                       input logic [31:0] rs, input logic [31:0] rt);
    e_valid  = v;
    e_flush  = f;
    e_md_cls = cls;
    e_rs     = rs;
    e_rt     = rt;
  endtask

  task automatic apply_stimulus(input logic v, input logic f, input logic [3:0] cls,
                                input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    drive(v, f, cls, rs, rt);
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;

    // Reset: state clear, outputs still decode combinationally.
    drive(1'b1, 1'b0, C_DIVU, 32'd9, 32'd3);
    @(negedge clk);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_start", 32'(xlu_start), 32'd1);
    check_output("rst_op", 32'(xlu_op), 32'd3);
    check_output("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, C_NONE, 32'd0, 32'd0);
    @(negedge clk);
    check_output("idle_busy", 32'(busy), 32'd0);

    // MULT 3 * -4, MFHI right behind it.
    apply_stimulus(1'b1, 1'b0, C_MULT, 32'd3, 32'hFFFF_FFFC);
    check_output("mul_start", 32'(xlu_start), 32'd1);
    check_output("mul_op", 32'(xlu_op), 32'd0);
    check_output("mul_in1", xlu_in1, 32'd3);
    check_output("mul_in2", xlu_in2, 32'hFFFF_FFFC);
    check_output("mul_stall0", 32'(stall), 32'd0);
    apply_stimulus(1'b1, 1'b0, C_MFHI, 32'd0, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      check_output($sformatf("mul_stall_t%0d", i), 32'(stall), 32'd1);
      check_output($sformatf("mul_busy_t%0d", i), 32'(busy), 32'd1);
      check_output($sformatf("mul_nostart_t%0d", i), 32'(xlu_start), 32'd0);
      apply_stimulus(1'b1, 1'b0, C_MFHI, 32'd0, 32'd0);
    end
    check_output("mul_stall_t6", 32'(stall), 32'd0);
    check_output("mul_busy_t6", 32'(busy), 32'd0);
    check_output("mfhi_data", mf_data, 32'hFFFF_FFFF);

    // DIVU 100/7 then DIV by zero back-to-back.
    apply_stimulus(1'b1, 1'b0, C_DIVU, 32'd100, 32'd7);
    check_output("divu_start", 32'(xlu_start), 32'd1);
    check_output("divu_op", 32'(xlu_op), 32'd3);
    apply_stimulus(1'b1, 1'b0, C_DIV, 32'h80, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      check_output($sformatf("div_stall_t%0d", i), 32'(stall), 32'd1);
      check_output($sformatf("div_busy_t%0d", i), 32'(busy), 32'd1);
      apply_stimulus(1'b1, 1'b0, C_DIV, 32'h80, 32'd0);
    end
    check_output("div2_start", 32'(xlu_start), 32'd1);
    check_output("div2_op", 32'(xlu_op), 32'd2);
    check_output("div2_stall", 32'(stall), 32'd0);
    check_output("div2_busy_t11", 32'(busy), 32'd0);
    // Non-MD classes while busy: NONE and the unused class 12.
    for (int i = 12; i <= 21; i++) begin
      apply_stimulus(1'b1, 1'b0, (i % 2 == 0) ? 4'd12 : C_NONE, 32'd5, 32'd6);
      check_output($sformatf("div2_busy_t%0d", i), 32'(busy), 32'd1);
      check_output($sformatf("nonmd_stall_t%0d", i), 32'(stall), 32'd0);
      check_output($sformatf("nonmd_start_t%0d", i), 32'(xlu_start), 32'd0);
      check_output($sformatf("nonmd_mf_t%0d", i), mf_data, 32'd0);
    end
    apply_stimulus(1'b0, 1'b0, C_NONE, 32'd0, 32'd0);
    check_output("div2_busy_t22", 32'(busy), 32'd0);

    // Reset pulled in the middle of a DIV.
    apply_stimulus(1'b1, 1'b0, C_DIV, 32'd50, 32'd5);
    check_output("rdiv_start", 32'(xlu_start), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(1'b0, 1'b0, C_NONE, 32'd0, 32'd0);
    end
    apply_stimulus(1'b1, 1'b0, C_MFHI, 32'd0, 32'd0);
    check_output("rdiv_stall_t4", 32'(stall), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_output("rdiv_busy_async", 32'(busy), 32'd0);
    check_output("rdiv_stall_async", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 1'b0, C_MULT, 32'd2, 32'd3);
    @(negedge clk);
    check_output("post_rst_start", 32'(xlu_start), 32'd1);
    check_output("post_rst_op", 32'(xlu_op), 32'd0);

    // Flush of the stalled MFLO behind it; the MULT still runs its 5 cycles.
    apply_stimulus(1'b1, 1'b0, C_MFLO, 32'd0, 32'd0);
    check_output("fl_stall_t1", 32'(stall), 32'd1);
    apply_stimulus(1'b1, 1'b1, C_MFLO, 32'd0, 32'd0);
    check_output("fl_stall_drop", 32'(stall), 32'd0);
    check_output("fl_nostart", 32'(xlu_start), 32'd0);
    check_output("fl_busy_t2", 32'(busy), 32'd1);
    for (int i = 3; i <= 5; i++) begin
      apply_stimulus(1'b0, 1'b0, C_NONE, 32'd0, 32'd0);
      check_output($sformatf("fl_busy_t%0d", i), 32'(busy), 32'd1);
    end
    apply_stimulus(1'b1, 1'b0, C_MFLO, 32'd0, 32'd0);
    check_output("fl_busy_t6", 32'(busy), 32'd0);
    check_output("fl_stall_t6", 32'(stall), 32'd0);
    check_output("mflo_data", mf_data, 32'd6);

    // Flush on the MULT itself never issues.
    apply_stimulus(1'b1, 1'b1, C_MULT, 32'd7, 32'd7);
    check_output("flmul_start", 32'(xlu_start), 32'd0);
    apply_stimulus(1'b0, 1'b0, C_NONE, 32'd0, 32'd0);
    check_output("flmul_busy", 32'(busy), 32'd0);

    // MTHI/MTLO followed directly by the matching move-from.
    apply_stimulus(1'b1, 1'b0, C_MTHI, 32'hDEAD_BEEF, 32'd0);
    check_output("mthi_start", 32'(xlu_start), 32'd1);
    check_output("mthi_op", 32'(xlu_op), 32'd4);
    apply_stimulus(1'b1, 1'b0, C_MFHI, 32'd0, 32'd0);
    check_output("mthi_busy", 32'(busy), 32'd0);
    check_output("mthi_stall", 32'(stall), 32'd0);
    check_output("mthi_mf", mf_data, 32'hDEAD_BEEF);
    apply_stimulus(1'b1, 1'b0, C_MTLO, 32'h1234_5678, 32'd0);
    check_output("mtlo_op", 32'(xlu_op), 32'd5);
    apply_stimulus(1'b1, 1'b0, C_MFLO, 32'd0, 32'd0);
    check_output("mtlo_stall", 32'(stall), 32'd0);
    check_output("mtlo_mf", mf_data, 32'h1234_5678);
    check_output("mf_idle_op", 32'(xlu_op), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/md_issue.md
# md_issue

Pipeline-side issue and hazard controller for the multiply/divide unit `xlu`. It sits in the E stage. It decodes the E-stage multiply/divide class, drives the `xlu` request port, and tracks the unit's fixed latency with an internal countdown, because `xlu` has no busy output. It stalls dependent E-stage instructions and returns HI/LO data for `mfhi`/`mflo`.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: occupancy of `mult`/`multu`, in cycles after issue.
- `DIV_CYCLES`, default 10: occupancy of `div`/`divu`, in cycles after issue.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; `reset==0` clears all state immediately.
- `e_valid`  in  1  E-stage instruction is valid.
- `e_flush`  in  1  E-stage instruction is being killed this cycle.
- `e_md_cls`  in  4  MD class: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8; 9–15 are treated as NONE.
- `e_rs`  in  32  forwarded rs operand.
- `e_rt`  in  32  forwarded rt operand.
- `xlu_start`  out  1  one-cycle issue strobe to `xlu`.
- `xlu_op`  out  3  mult=000, multu=001, div=010, divu=011, mthi=100, mtlo=101.
- `xlu_in1`  out  32  equals `e_rs`.
- `xlu_in2`  out  32  equals `e_rt`.
- `hi_out`  in  32  HI value from `xlu`.
- `lo_out`  in  32  LO value from `xlu`.
- `stall`  out  1  freeze F/D/E, insert a bubble into M.
- `busy`  out  1  `xlu` occupied.
- `mf_data`  out  32  result of MFHI/MFLO.

## Operation
State register `st` with states IDLE, MUL_BUSY, DIV_BUSY, plus a countdown `cnt` of width `$clog2(DIV_CYCLES+1)`.

Signal definitions:
- `md_any` = `e_valid & ~e_flush & (e_md_cls` in 1..8`)`.
- `stall` = `md_any & (st != IDLE)`. This is combinational, and stays combinational while `reset` is 0.
- `xlu_start` = `e_valid & ~e_flush & ~stall & (e_md_cls` in 1..6`)`.
- `xlu_op` follows the class mapping above and is 000 when not issuing.
- `xlu_in1`/`xlu_in2` are passthroughs.

State transitions:
- Issue of MULT/MULTU: `st`<=MUL_BUSY, `cnt`<=`MULT_CYCLES`.
- Issue of DIV/DIVU: `st`<=DIV_BUSY, `cnt`<=`DIV_CYCLES`.
- Issue of MTHI/MTLO: strobe only; `st` stays IDLE (single-cycle write inside `xlu`).
- In a BUSY state: `cnt`<=`cnt-1`. When `cnt==1`, the next state is IDLE and `cnt`<=0.
- `busy` = `(st != IDLE)`, registered.

Read path:
- `mf_data` = `hi_out` for MFHI, `lo_out` for MFLO, otherwise 0.
- `mf_data` is meaningful only when `~stall`.

Boundary rules:
- **Divide by zero:** still issued and occupies the full `DIV_CYCLES`. HI/LO contents are unspecified. No trap is raised.
- **Flush while BUSY:** the in-flight operation is not cancelled. Flush only suppresses a new issue.
- **Flush of a stalled MD instruction:** `stall` drops the same cycle.
- **Back-to-back MD ops:** the second op stalls until IDLE, then issues in the first IDLE cycle. There is no dead cycle.
- **MTHI/MTLO followed by MFHI/MFLO:** no stall. `xlu` must bypass or commit within one cycle.
- **Reset asserted mid-operation:**
  - `st`=IDLE, `cnt`=0, `busy`=0 asynchronously.
  - `xlu` is reset by the same `reset`.
- **Reset values:** `busy`=0.
- **Outputs during reset:** `stall`, `xlu_start`, `xlu_op` and `mf_data` remain combinational from inputs, with `st`=IDLE.

## Timing
- Issue at cycle t (`xlu_start`=1): `busy`=1 on cycles t+1 .. t+N, where N is the occupancy. Cycle t+N+1 is IDLE.
- An MFHI/MFLO in E at t+1 stalls exactly N cycles and reads at t+N+1.
- Contract on `xlu`: `hi_out`/`lo_out` are final by cycle t+N+1.
- `stall` path: `e_*` -> `stall` is combinational, one gate level behind `st`. There is no registered delay.
- Throughput: one MD op per N+1 cycles when ops are back-to-back.

## Structure
- Shared package `md_pkg` holds:
  - the `md_cls_t` 4-bit enum (values above);
  - the `xlu_op_t` 3-bit constants, which `xlu` must also adopt;
  - `MD_MULT_CYCLES`=5 and `MD_DIV_CYCLES`=10 as defaults;
  - the `md_st_t` enum IDLE/MUL_BUSY/DIV_BUSY.
- One sub-module, `md_busy_cnt`:
  - contents: load/decrement countdown with an async active-low clear;
  - inputs: `load`, `load_val`;
  - outputs: `cnt`, `last` (`cnt==1`).
- `md_issue` holds the class decode, FSM and `mf_data` mux.

## Test plan
- **MULT with MFHI behind it.** MULT rs=3, rt=0xFFFFFFFC (-4), then MFHI in E at t+1.
  - Required: `xlu_start` for one cycle with `xlu_op`=000, `xlu_in1`=3, `xlu_in2`=0xFFFFFFFC.
  - `stall` high t+1..t+5; `mf_data` = `hi_out` at t+6.
- **DIVU then DIV back-to-back.** DIVU 100/7, then DIV in E at t+1.
  - Required: `stall` high for 10 cycles.
  - Second `xlu_start` at t+11 with `xlu_op`=011 then 010.
  - `busy` high t+1..t+10 and t+12..t+21.
- **Reset mid-DIV.** Pull `reset`=0 at t+4 of a DIV, release it, then issue MULT.
  - Required: `busy`=0 and `stall`=0 immediately.
  - MULT issues on the first cycle after release.
- **Flush handling.** Flush during a stalled MFLO behind a MULT: `stall` drops the same cycle, and the MULT still completes after 5 cycles. Flush on MULT itself: no `xlu_start`, `busy` stays 0.
- **MTHI then MFHI.** MTHI rs=0xDEADBEEF, then MFHI next cycle.
  - Required: `xlu_op`=100 strobe, no stall, `mf_data`=0xDEADBEEF.
- **Non-MD classes while BUSY.** NONE and class 12 in E while BUSY.
  - Required: `stall`=0, `xlu_start`=0, `mf_data`=0.
